// File: rtl/pu_wb_gpr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pu_wb_gpr_arb_pkg
//  Brief    : Shared widths, build constants and helpers for the GPR
//             write-back arbiter and its long-latency write buffer.
//  Revision : 1.0  initial release
// ============================================================================
package pu_wb_gpr_arb_pkg;

  // Word and GPR address widths shared with the rest of the processor unit
  localparam int WORD_DATA_W   = 32;
  localparam int PU_GPR_ADDR_W = 5;

  // Build-time defaults for the write-back arbiter
  localparam int PU_WB_FIFO_DEPTH   = 4;
  localparam int PU_WB_STARVE_LIMIT = 8;

  typedef logic [WORD_DATA_W-1:0]   WordDataBus;
  typedef logic [PU_GPR_ADDR_W-1:0] PuGprAddrBus;

  // r0 is hard-wired to zero, so writes to it are dropped
  function automatic logic is_gpr_zero(input PuGprAddrBus a);
    return (a == '0);
  endfunction

endpackage : pu_wb_gpr_arb_pkg
`default_nettype wire

// File: rtl/pu_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pu_wb_fifo
//  Brief    : Synchronous write buffer for long-latency unit results.
//             Exposes every slot's address and valid flag so that the
//             issue stage can detect pending writes to a source operand.
//  Revision : 1.0  initial release
// ============================================================================
module pu_wb_fifo
  import pu_wb_gpr_arb_pkg::*;
#(
  parameter  int DEPTH = PU_WB_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          i_push,
  input  PuGprAddrBus                   i_push_addr,
  input  WordDataBus                    i_push_data,
  input  logic                          i_pop,
  output PuGprAddrBus                   o_head_addr,
  output WordDataBus                    o_head_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [CW-1:0]                 o_count,
  output logic [DEPTH-1:0]              o_ent_valid,
  output PuGprAddrBus [DEPTH-1:0]       o_ent_addr
);

  PuGprAddrBus     r_addr [DEPTH];
  WordDataBus      r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // Overflow and underflow requests are ignored rather than corrupting state
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop  & ~o_empty;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_ent_valid = r_valid;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign o_ent_addr[g] = r_addr[g];
    end
  endgenerate

  // Payload storage; validity is tracked separately so no reset is needed
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  // Per-slot valid flags feed the operand busy compare
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_valid <= '0;
    end else begin
      if (w_do_pop)  r_valid[r_rd_ptr] <= 1'b0;
      if (w_do_push) r_valid[r_wr_ptr] <= 1'b1;
    end
  end

endmodule : pu_wb_fifo
`default_nettype wire

// File: rtl/pu_wb_gpr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : pu_wb_gpr_arb
//  Brief    : Single-port GPR write-back arbiter. The pipeline write-back
//             always wins; long-latency results are buffered and drained
//             when the pipeline is idle, with a bubble request raised when
//             the buffer has been starved for too long.
//  Revision : 1.0  initial release
// ============================================================================
module pu_wb_gpr_arb
  import pu_wb_gpr_arb_pkg::*;
#(
  parameter  int FIFO_DEPTH   = PU_WB_FIFO_DEPTH,
  parameter  int STARVE_LIMIT = PU_WB_STARVE_LIMIT,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1,
  localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        wbp_en,
  input  PuGprAddrBus wbp_addr,
  input  WordDataBus  wbp_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  PuGprAddrBus lu_addr,
  input  WordDataBus  lu_data,
  input  PuGprAddrBus chk0_addr,
  input  PuGprAddrBus chk1_addr,
  output logic        chk0_busy,
  output logic        chk1_busy,
  output logic        stall_req,
  output PuGprAddrBus wr_addr,
  output logic        wr_en,
  output WordDataBus  wr_data
);

  PuGprAddrBus                 w_head_addr;
  WordDataBus                  w_head_data;
  logic                        w_full;
  logic                        w_empty;
  logic [CW-1:0]               w_count;
  logic [FIFO_DEPTH-1:0]       w_ent_valid;
  PuGprAddrBus [FIFO_DEPTH-1:0] w_ent_addr;
  logic                        w_lu_accept;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_hit0;
  logic                        w_hit1;
  logic [SW-1:0]               w_starve_nxt;

  logic                        r_wr_en;
  PuGprAddrBus                 r_wr_addr;
  WordDataBus                  r_wr_data;
  logic [SW-1:0]               r_starve;
  logic                        r_stall_req;

  // Readiness comes from the registered occupancy only
  assign lu_ready    = rst_ & (w_count < CW'(FIFO_DEPTH));
  assign w_lu_accept = lu_valid & rst_ & ~w_full;
  // Writes to r0 are acknowledged but never stored
  assign w_push      = w_lu_accept & ~is_gpr_zero(lu_addr);
  // The buffer drains only on cycles the pipeline leaves the port free
  assign w_pop       = ~wbp_en & ~w_empty;

  pu_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_        (rst_),
    .i_push      (w_push),
    .i_push_addr (lu_addr),
    .i_push_data (lu_data),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_ent_valid (w_ent_valid),
    .o_ent_addr  (w_ent_addr)
  );

  // Registered GPR write port: pipeline first, then buffer head
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (wbp_en) begin
      r_wr_en   <= ~is_gpr_zero(wbp_addr);
      r_wr_addr <= wbp_addr;
      r_wr_data <= wbp_data;
    end else if (!w_empty) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_head_addr;
      r_wr_data <= w_head_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  // Count consecutive cycles the buffer is blocked by the pipeline
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || !wbp_en) begin
      w_starve_nxt = '0;
    end else if (r_starve != SW'(STARVE_LIMIT)) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // Starvation counter and its registered bubble request
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_starve    <= '0;
      r_stall_req <= 1'b0;
    end else begin
      r_starve    <= w_starve_nxt;
      r_stall_req <= (w_starve_nxt == SW'(STARVE_LIMIT));
    end
  end

  assign stall_req = r_stall_req;

  // Match operand addresses against buffered entries and the write in flight
  always_comb begin
    w_hit0 = r_wr_en && (r_wr_addr == chk0_addr);
    w_hit1 = r_wr_en && (r_wr_addr == chk1_addr);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_addr[i] == chk0_addr)) w_hit0 = 1'b1;
      if (w_ent_valid[i] && (w_ent_addr[i] == chk1_addr)) w_hit1 = 1'b1;
    end
  end

  assign chk0_busy = ~is_gpr_zero(chk0_addr) & w_hit0;
  assign chk1_busy = ~is_gpr_zero(chk1_addr) & w_hit1;

endmodule : pu_wb_gpr_arb
`default_nettype wire

// File: tb/tb_pu_wb_gpr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pu_wb_gpr_arb
//  Brief    : Self-checking bench for pu_wb_gpr_arb: directed scenarios
//             plus random traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pu_wb_gpr_arb;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_;
  logic        wbp_en;
  logic [4:0]  wbp_addr;
  logic [31:0] wbp_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [4:0]  chk0_addr;
  logic [4:0]  chk1_addr;
  logic        chk0_busy;
  logic        chk1_busy;
  logic        stall_req;
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;

  int n_pass = 0;
  int n_fail = 0;

  // Reference model state: buffered writes in order, last write, starvation
  ent_t        m_q[$];
  logic        m_wr_en   = 1'b0;
  logic [4:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;
  int          m_starve  = 0;
  logic        m_stall   = 1'b0;

  pu_wb_gpr_arb #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .wbp_en    (wbp_en),
    .wbp_addr  (wbp_addr),
    .wbp_data  (wbp_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_addr   (lu_addr),
    .lu_data   (lu_data),
    .chk0_addr (chk0_addr),
    .chk1_addr (chk1_addr),
    .chk0_busy (chk0_busy),
    .chk1_busy (chk1_busy),
    .stall_req (stall_req),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_wr_en && m_wr_addr == a) return 1'b1;
    foreach (m_q[i]) if (m_q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: advance the reference model with the inputs seen at the edge
  task automatic cyc();
    bit   nonempty;
    bit   accept;
    ent_t e;
    @(posedge clk);
    if (!rst_) begin
      m_q.delete();
      m_starve = 0;
      m_wr_en  = 1'b0;
      m_stall  = 1'b0;
    end else begin
      nonempty = (m_q.size() > 0);
      accept   = lu_valid && (m_q.size() < DEPTH);
      if (wbp_en) begin
        m_wr_en = (wbp_addr != 5'd0);
        if (m_wr_en) begin
          m_wr_addr = wbp_addr;
          m_wr_data = wbp_data;
        end
      end else if (nonempty) begin
        e = m_q.pop_front();
        m_wr_en   = 1'b1;
        m_wr_addr = e.a;
        m_wr_data = e.d;
      end else begin
        m_wr_en = 1'b0;
      end
      if (nonempty && wbp_en) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                    m_starve = 0;
      m_stall = (m_starve == LIMIT);
      if (accept && lu_addr != 5'd0) m_q.push_back('{a: lu_addr, d: lu_data});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wbp_en = 1'b0; lu_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_wr: en=%b addr=%0d data=%h want 0/0/0", wr_en, wr_addr, wr_data);
    end else n_pass++;
    if (stall_req !== 1'b0 || lu_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: stall=%b lu_ready=%b want 0/0", stall_req, lu_ready);
    end else n_pass++;
    chk0_addr = 5'd5; chk1_addr = 5'd9;
    rst_ = 1'b1;
    #1;
    if (lu_ready !== 1'b1 || chk0_busy !== 1'b0 || chk1_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: lu_ready=%b busy=%b%b want 1/00", lu_ready, chk0_busy, chk1_busy);
    end else n_pass++;
  endtask

  task automatic test_pipeline();
    idle(2);
    wbp_en = 1'b1; wbp_addr = 5'd5; wbp_data = 32'h12345678;
    cyc();
    wbp_en = 1'b0;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h12345678) begin
      n_fail++; $display("FAIL pipe_write: en=%b addr=%0d data=%h want 1/5/12345678", wr_en, wr_addr, wr_data);
    end else n_pass++;
    cyc();
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL pipe_one_shot: en=%b want 0", wr_en);
    end else n_pass++;
  endtask

  task automatic test_lu();
    idle(2);
    chk0_addr = 5'd9; chk1_addr = 5'd0;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'hCAFEBABE;
    cyc();
    lu_valid = 1'b0;
    if (wr_en !== 1'b0 || chk0_busy !== 1'b1) begin
      n_fail++; $display("FAIL lu_buffered: en=%b busy=%b want 0/1", wr_en, chk0_busy);
    end else n_pass++;
    cyc();
    if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hCAFEBABE || chk0_busy !== 1'b1) begin
      n_fail++; $display("FAIL lu_write: en=%b addr=%0d data=%h busy=%b want 1/9/cafebabe/1", wr_en, wr_addr, wr_data, chk0_busy);
    end else n_pass++;
    cyc();
    if (wr_en !== 1'b0 || chk0_busy !== 1'b0) begin
      n_fail++; $display("FAIL lu_done: en=%b busy=%b want 0/0", wr_en, chk0_busy);
    end else n_pass++;
  endtask

  task automatic test_full();
    idle(2);
    wbp_en = 1'b1; wbp_addr = 5'd20; wbp_data = 32'h0000_0020;
    for (int i = 1; i <= DEPTH; i++) begin
      lu_valid = 1'b1; lu_addr = 5'(i); lu_data = 32'h100 + 32'(i);
      if (lu_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_ready_%0d: lu_ready=%b want 1", i, lu_ready);
      end else n_pass++;
      cyc();
    end
    lu_valid = 1'b0;
    if (lu_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 5'd20) begin
      n_fail++; $display("FAIL full_block: lu_ready=%b en=%b addr=%0d want 0/1/20", lu_ready, wr_en, wr_addr);
    end else n_pass++;
    wbp_en = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc();
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL full_drain_%0d: en=%b addr=%0d data=%h", i, wr_en, wr_addr, wr_data);
      end else n_pass++;
      if (lu_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_ready_after_pop_%0d: lu_ready=%b want 1", i, lu_ready);
      end else n_pass++;
    end
  endtask

  task automatic test_starve();
    idle(2);
    wbp_en = 1'b1; wbp_addr = 5'd21; wbp_data = 32'h0000_0021;
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h0000_0303;
    cyc();
    lu_valid = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      cyc();
      if (stall_req !== (k == LIMIT)) begin
        n_fail++; $display("FAIL starve_cnt_%0d: stall=%b want %b", k, stall_req, (k == LIMIT));
      end else n_pass++;
    end
    wbp_data = 32'h0000_0099;
    cyc();
    if (stall_req !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 5'd21 || wr_data !== 32'h99) begin
      n_fail++; $display("FAIL starve_hold: stall=%b en=%b addr=%0d data=%h want 1/1/21/99", stall_req, wr_en, wr_addr, wr_data);
    end else n_pass++;
    wbp_en = 1'b0;
    cyc();
    if (stall_req !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h303) begin
      n_fail++; $display("FAIL starve_release: stall=%b en=%b addr=%0d data=%h want 0/1/3/303", stall_req, wr_en, wr_addr, wr_data);
    end else n_pass++;
  endtask

  task automatic test_zero();
    idle(2);
    chk0_addr = 5'd0; chk1_addr = 5'd0;
    for (int k = 0; k < 3; k++) begin
      wbp_en = 1'b1; wbp_addr = 5'd0; wbp_data = 32'hDEAD0000 + 32'(k);
      lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hBEEF0000 + 32'(k);
      cyc();
      if (wr_en !== 1'b0 || lu_ready !== 1'b1 || chk0_busy !== 1'b0 || chk1_busy !== 1'b0) begin
        n_fail++; $display("FAIL zero_%0d: en=%b lu_ready=%b busy=%b%b want 0/1/00", k, wr_en, lu_ready, chk0_busy, chk1_busy);
      end else n_pass++;
    end
    idle(1);
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL zero_not_buffered: en=%b want 0", wr_en);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    idle(2);
    wbp_en = 1'b1; wbp_addr = 5'd22; wbp_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      lu_valid = 1'b1; lu_addr = 5'd11 + 5'(i); lu_data = 32'hA0 + 32'(i);
      cyc();
    end
    lu_valid = 1'b0; wbp_en = 1'b0;
    rst_ = 1'b0;
    #1;
    if (wr_en !== 1'b0 || lu_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_assert: en=%b lu_ready=%b want 0/0", wr_en, lu_ready);
    end else n_pass++;
    cyc();
    rst_ = 1'b1;
    chk0_addr = 5'd11; chk1_addr = 5'd13;
    #1;
    if (lu_ready !== 1'b1 || chk0_busy !== 1'b0 || chk1_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_release: lu_ready=%b busy=%b%b want 1/00", lu_ready, chk0_busy, chk1_busy);
    end else n_pass++;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (wr_en !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_discard_%0d: en=%b addr=%0d want en 0", k, wr_en, wr_addr);
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    idle(2);
    for (int n = 0; n < 400; n++) begin
      wbp_en    = ($urandom_range(0, 9) < 6);
      wbp_addr  = 5'($urandom_range(0, 7));
      wbp_data  = $urandom();
      lu_valid  = 1'($urandom_range(0, 1));
      lu_addr   = 5'($urandom_range(0, 7));
      lu_data   = $urandom();
      chk0_addr = 5'($urandom_range(0, 7));
      chk1_addr = 5'($urandom_range(0, 7));
      #1;
      if (lu_ready !== (m_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", n, lu_ready, (m_q.size() < DEPTH));
      end else n_pass++;
      if (chk0_busy !== m_busy(chk0_addr) || chk1_busy !== m_busy(chk1_addr)) begin
        n_fail++; $display("FAIL rnd_busy@%0d: got %b%b want %b%b", n, chk0_busy, chk1_busy, m_busy(chk0_addr), m_busy(chk1_addr));
      end else n_pass++;
      cyc();
      if (wr_en !== m_wr_en) begin
        n_fail++; $display("FAIL rnd_wr_en@%0d: got %b want %b", n, wr_en, m_wr_en);
      end else n_pass++;
      if (m_wr_en) begin
        if (wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
          n_fail++; $display("FAIL rnd_wr@%0d: got %0d/%h want %0d/%h", n, wr_addr, wr_data, m_wr_addr, m_wr_data);
        end else n_pass++;
      end
      if (stall_req !== m_stall) begin
        n_fail++; $display("FAIL rnd_stall@%0d: got %b want %b", n, stall_req, m_stall);
      end else n_pass++;
    end
  endtask

  initial begin
    rst_ = 1'b0;
    wbp_en = 1'b0; wbp_addr = '0; wbp_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    chk0_addr = '0; chk1_addr = '0;
    test_reset();
    test_pipeline();
    test_lu();
    test_full();
    test_starve();
    test_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule : tb_pu_wb_gpr_arb
`default_nettype wire

// File: doc/pu_wb_gpr_arb.md
PU_WB_GPR_ARB -- requirements
Module: pu_wb_gpr_arb

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- FIFO_DEPTH, 4, long-latency write buffer entries (power of two, >=2).
- STARVE_LIMIT, 8, consecutive blocked cycles before a pipeline bubble is requested.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_, in, 1, asynchronous active-low reset.
- wbp_en, in, 1, pipeline write-back valid.
- wbp_addr, in, 5, pipeline destination GPR.
- wbp_data, in, 32, pipeline write data.
- lu_valid, in, 1, long-latency unit (load/mul/div) result valid.
- lu_ready, out, 1, result accepted this cycle when lu_valid is also high.
- lu_addr, in, 5, long-latency destination GPR.
- lu_data, in, 32, long-latency write data.
- chk0_addr, in, 5, ID source operand 0 address.
- chk1_addr, in, 5, ID source operand 1 address.
- chk0_busy, out, 1, a write to chk0_addr is pending.
- chk1_busy, out, 1, a write to chk1_addr is pending.
- stall_req, out, 1, request one pipeline write-back bubble.
- wr_addr, out, 5, GPR file write address.
- wr_en, out, 1, GPR file write enable.
- wr_data, out, 32, GPR file write data.

Function
REQ-003 wr_addr, wr_en and wr_data SHALL be registered; exactly one GPR write SHALL be issued per cycle at most.
REQ-004 Each cycle, the selection SHALL be wbp_en first; otherwise the FIFO head if the FIFO is non-empty; otherwise no write.
REQ-005 The selected write SHALL appear on wr_* on the next clock edge, with wr_en high for exactly one cycle per write.
REQ-006 A pipeline write with wbp_addr==0 SHALL NOT produce wr_en; it SHALL still count as the pipeline winning the port for that cycle.
REQ-007 lu_ready SHALL be high iff FIFO count < FIFO_DEPTH and rst_ is high; it SHALL depend only on registered state.
REQ-008 When lu_valid and lu_ready are both high, the entry SHALL be enqueued. If lu_addr==0, the entry SHALL be accepted and discarded without being enqueued.
REQ-009 FIFO order SHALL be preserved. Minimum latency from lu acceptance to wr_en SHALL be 2 cycles.
REQ-010 Simultaneous push and pop SHALL keep the count unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-011 chkN_busy SHALL be 1 iff chkN_addr!=0 and chkN_addr matches the address of any valid FIFO entry, or (wr_en && wr_addr==chkN_addr).
REQ-012 chkN_busy SHALL be combinational from registered state and chkN_addr only.
REQ-013 A starvation counter SHALL increment in each cycle where the FIFO is non-empty and wbp_en is high. It SHALL clear on any FIFO pop or when the FIFO is empty, and SHALL saturate at STARVE_LIMIT.
REQ-014 stall_req SHALL be registered and high while the counter equals STARVE_LIMIT.
REQ-015 If wbp_en is high while stall_req is high, the pipeline write SHALL still win and no data SHALL be lost; stall_req SHALL remain high.
REQ-016 Ordering hazards between a pipeline write and a buffered write to the same register are the issuing stage's responsibility, via chkN_busy. The block SHALL NOT reorder or merge writes.

Reset
REQ-017 While rst_ is low:
- wr_en=0, wr_addr=0, wr_data=0, stall_req=0, lu_ready=0.
- FIFO count, pointers and starvation counter SHALL be 0.
- FIFO entries SHALL be marked invalid.
REQ-018 A reset asserted mid-operation SHALL discard all buffered writes. The first cycle after release SHALL show lu_ready=1, chk0_busy=0 and chk1_busy=0.

Structure
REQ-019 PU_WB_FIFO_DEPTH and PU_WB_STARVE_LIMIT SHALL be defined in pu.h. Widths SHALL reuse WordDataBus and PuGprAddrBus.
REQ-020 Buffering SHALL be a sub-module pu_wb_fifo: a synchronous FIFO with push/pop, full/empty/count outputs, and per-entry address/valid visibility for the busy compare.
REQ-021 Arbitration, the output register and the starvation counter SHALL reside in pu_wb_gpr_arb.

Verification
REQ-022 The bench SHALL cover the following scenarios (stimulus -> required response):
- Pipeline only: wbp_en=1, addr=5, data=0x12345678 -> next cycle wr_en=1, wr_addr=5, wr_data=0x12345678.
- LU with pipeline idle: lu push addr=9, data=0xCAFEBABE -> wr_en two cycles later. chk0_addr=9 gives busy=1 until the cycle after that write.
- Full FIFO: 4 lu pushes to addr 1..4 with wbp_en held high -> lu_ready=0 after the 4th push. Dropping wbp_en gives writes 1,2,3,4 in order on consecutive cycles.
- Starvation: 1 buffered entry with wbp_en high for 8 cycles -> stall_req=1. One wbp_en=0 cycle pops the entry and clears stall_req the following cycle.
- Zero register: wbp_addr=0 and lu_addr=0 -> wr_en never asserted, FIFO count stays 0, chk*_busy=0.
- Reset mid-operation: 3 entries buffered, rst_ pulsed low -> wr_en=0, count=0, lu_ready=1 after release, and none of the 3 entries is ever written.
